// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-addressed requests to a word-addressed data memory,
// with read-modify-write for sub-word stores and sign/zero-extended load return.
module load_store_unit #(
  parameter int MEM_AW = 7,
  parameter int XLEN   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              memRead_i,
  input  logic              memWrite_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wData_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rData_o,
  output logic              err_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, RMW_WR, DONE} state_t;

  state_t            state_q;
  logic              done_q, err_q;
  logic [XLEN-1:0]   rdata_q, merged_q, merged_d;
  logic [MEM_AW-1:0] addr_q;

  logic              active, is_store, illegal, misaligned, req_err, acc_ok;
  logic [1:0]        lane;
  logic [MEM_AW-1:0] waddr;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [XLEN-1:0]   load_val;
  logic              unused_addr_bits;

  // Upper address bits wrap onto the 128-word memory.
  assign unused_addr_bits = ^addr_i[XLEN-1:MEM_AW+2];

  assign lane     = addr_i[1:0];
  assign waddr    = addr_i[MEM_AW+1:2];
  assign is_store = memWrite_i;
  assign active   = (state_q == IDLE) && valid_i && (memRead_i || memWrite_i);
  assign req_err  = illegal || misaligned;
  assign acc_ok   = active && !req_err;
  assign ready_o  = (state_q == IDLE);
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign rData_o  = rdata_q;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3_i)
      3'b000: ;
      3'b001: misaligned = addr_i[0];
      3'b010: misaligned = |addr_i[1:0];
      3'b100: illegal    = is_store;
      3'b101: begin
        illegal    = is_store;
        misaligned = addr_i[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign byte_v = mem_rdata_i[{lane, 3'b000} +: 8];
  assign half_v = mem_rdata_i[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_i)
      3'b000:  load_val = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b001:  load_val = {{(XLEN-16){half_v[15]}}, half_v};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_v};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, half_v};
      default: load_val = mem_rdata_i;
    endcase
  end

  always_comb begin
    merged_d = mem_rdata_i;
    if (funct3_i == 3'b000) merged_d[{lane, 3'b000} +: 8] = wData_i[7:0];
    else                    merged_d[{lane[1], 4'b0000} +: 16] = wData_i[15:0];
  end

  // Memory port is quiet (all zeros) except in an accept cycle or the RMW write cycle.
  always_comb begin
    mem_addr_o  = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_wdata_o = '0;
    if (state_q == RMW_WR) begin
      mem_addr_o  = addr_q;
      mem_write_o = 1'b1;
      mem_wdata_o = merged_q;
    end else if (acc_ok) begin
      mem_addr_o = waddr;
      if (is_store && funct3_i == 3'b010) begin
        mem_write_o = 1'b1;
        mem_wdata_o = wData_i;
      end else begin
        mem_read_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      merged_q <= '0;
      addr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (active) begin
            if (req_err) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (!is_store) begin
              rdata_q <= load_val;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (funct3_i == 3'b010) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              merged_q <= merged_d;
              addr_q   <= waddr;
              state_q  <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
